// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART byte receiver feeding a 5-byte command frame parser (55 ID DH DL SUM).
// Latency: rx_valid one clk after the stop-bit sample; cmd_valid/chk_err one clk after the SUM byte's rx_valid.
// Backpressure: none. The serial line cannot be stalled, so every result is a single-cycle strobe with no ready.
// Ports: clk, rst_n (async, active-low); uart_rx serial in (idle high, asynchronous to clk);
//        rx_data/rx_valid/frame_err carry byte results; cmd_id/cmd_data/cmd_valid/chk_err carry frame results.
module uart_cmd_rx #(
  parameter int CLK_FRE      = 50,
  parameter int UART_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [7:0]  cmd_id,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  output logic        chk_err
);

  localparam int BIT_CYCLES = CLK_FRE * 1000000 / UART_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int TMO_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES);

  localparam logic [7:0] HDR_BYTE = 8'h55;

  // ------------------------------------------------------------------
  // Input synchroniser. rx_prev is kept for edge detection; all three
  // stages reset to the idle-high level so reset never fakes an edge.
  // ------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Falling edge only: a line parked low (break) cannot retrigger.
  assign rx_fall = rx_prev & ~rx_sync;

  // ------------------------------------------------------------------
  // Byte FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;

  bstate_t          bstate, bstate_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             half_hit, bit_hit;
  logic             cnt_clr, shift_en, stop_good, stop_bad;

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bstate <= B_IDLE;
    else        bstate <= bstate_nxt;
  end

  always_comb begin
    bstate_nxt = bstate;
    case (bstate)
      B_IDLE:  if (rx_fall) bstate_nxt = B_START;
      // A start bit that is high again at mid-point was a glitch.
      B_START: if (half_hit) bstate_nxt = rx_sync ? B_IDLE : B_DATA;
      B_DATA:  if (bit_hit && bit_idx == 3'd7) bstate_nxt = B_STOP;
      // Leave at the mid stop-bit sample so a back-to-back start edge is seen.
      B_STOP:  if (bit_hit) bstate_nxt = B_IDLE;
      default: bstate_nxt = B_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (bstate)
      B_IDLE:  cnt_clr = 1'b1;
      B_START: cnt_clr = half_hit;
      B_DATA: begin
        cnt_clr  = bit_hit;
        shift_en = bit_hit;
      end
      B_STOP: begin
        cnt_clr   = bit_hit;
        stop_good = bit_hit & rx_sync;
        stop_bad  = bit_hit & ~rx_sync;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (bstate == B_START)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 1'b1;
      // LSB arrives first, so shift in from the top.
      if (shift_en)
        shreg <= {rx_sync, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_good;
      frame_err <= stop_bad;
      if (stop_good)
        rx_data <= shreg;
    end
  end

  // ------------------------------------------------------------------
  // Frame parser FSM
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {P_HDR, P_ID, P_DH, P_DL, P_SUM} pstate_t;

  pstate_t          pstate, pstate_nxt;
  logic [TMO_W-1:0] tcnt;
  logic [7:0]       id_r, dh_r, dl_r, sum_calc;
  logic             tmo_hit, load_id, load_dh, load_dl, sum_ok, sum_bad;

  assign tmo_hit = (pstate != P_HDR) && (tcnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pstate <= P_HDR;
    else        pstate <= pstate_nxt;
  end

  always_comb begin
    pstate_nxt = pstate;
    if (frame_err) begin
      pstate_nxt = P_HDR;
    end else if (rx_valid) begin
      case (pstate)
        P_HDR:   if (rx_data == HDR_BYTE) pstate_nxt = P_ID;
        // Past the header 0x55 is plain payload; there is no resync.
        P_ID:    pstate_nxt = P_DH;
        P_DH:    pstate_nxt = P_DL;
        P_DL:    pstate_nxt = P_SUM;
        P_SUM:   pstate_nxt = P_HDR;
        default: pstate_nxt = P_HDR;
      endcase
    end else if (tmo_hit) begin
      pstate_nxt = P_HDR;
    end
  end

  always_comb begin
    sum_calc = id_r + dh_r + dl_r;
    load_id  = rx_valid && (pstate == P_ID);
    load_dh  = rx_valid && (pstate == P_DH);
    load_dl  = rx_valid && (pstate == P_DL);
    sum_ok   = rx_valid && (pstate == P_SUM) && (rx_data == sum_calc);
    sum_bad  = rx_valid && (pstate == P_SUM) && (rx_data != sum_calc);
  end

  // Inter-byte timeout: restarts on each byte, idle while hunting for a header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt <= '0;
    else if (rx_valid || pstate == P_HDR)
      tcnt <= '0;
    else if (tcnt != TMO_LAST)
      tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r      <= '0;
      dh_r      <= '0;
      dl_r      <= '0;
      cmd_id    <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      if (load_id) id_r <= rx_data;
      if (load_dh) dh_r <= rx_data;
      if (load_dl) dl_r <= rx_data;
      cmd_valid <= sum_ok;
      chk_err   <= sum_bad;
      if (sum_ok) begin
        cmd_id   <= id_r;
        cmd_data <= {dh_r, dl_r};
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  // Main instance runs at 1 Mbaud (50 clk/bit) to keep the run short;
  // a second instance at the default 115200 (434 clk/bit) gets one byte.
  localparam int BIT_NS     = 1000;
  localparam int BIT_NS_DEF = 8680;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic        uart_rx_def;
  logic [7:0]  rx_data,  rx_data_def;
  logic        rx_valid, rx_valid_def;
  logic        frame_err, frame_err_def;
  logic [7:0]  cmd_id,   cmd_id_def;
  logic [15:0] cmd_data, cmd_data_def;
  logic        cmd_valid, cmd_valid_def;
  logic        chk_err,  chk_err_def;

  always #10 clk = ~clk;

  uart_cmd_rx #(.CLK_FRE(50), .UART_RATE(1000000), .TIMEOUT_BITS(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .cmd_id(cmd_id), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .chk_err(chk_err)
  );

  uart_cmd_rx u_dut_def (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx_def),
    .rx_data(rx_data_def), .rx_valid(rx_valid_def), .frame_err(frame_err_def),
    .cmd_id(cmd_id_def), .cmd_data(cmd_data_def), .cmd_valid(cmd_valid_def), .chk_err(chk_err_def)
  );

  // ---------------- strobe monitor (samples on the falling edge) ----------------
  int   cyc = 0, last_rxv_cyc = 0, cmd_lat = -1;
  int   n_rxv = 0, n_ferr = 0, n_cmd = 0, n_chk = 0;
  int   n_rxv_def = 0, n_ferr_def = 0;
  int   width_viol = 0, excl_viol = 0;
  logic p_rxv = 1'b0, p_ferr = 1'b0, p_cmd = 1'b0, p_chk = 1'b0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    p_rxv  <= rx_valid;
    p_ferr <= frame_err;
    p_cmd  <= cmd_valid;
    p_chk  <= chk_err;
    if (rx_valid) begin
      n_rxv        <= n_rxv + 1;
      last_rxv_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (cmd_valid) begin
      n_cmd   <= n_cmd + 1;
      cmd_lat <= cyc - last_rxv_cyc;
    end
    if (chk_err) n_chk <= n_chk + 1;
    if ((rx_valid && p_rxv) || (frame_err && p_ferr) || (cmd_valid && p_cmd) || (chk_err && p_chk))
      width_viol <= width_viol + 1;
    if (rx_valid && frame_err) excl_viol <= excl_viol + 1;
    if (rx_valid_def)  n_rxv_def  <= n_rxv_def + 1;
    if (frame_err_def) n_ferr_def <= n_ferr_def + 1;
  end

  // ---------------- checking helpers ----------------
  int vectors = 0;
  int miscompares = 0;
  int b_rxv, b_ferr, b_cmd, b_chk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rxv  = n_rxv;
    b_ferr = n_ferr;
    b_cmd  = n_cmd;
    b_chk  = n_chk;
  endtask

  // Move off the sampling edge before reading monitor counters.
  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bns, input bit def_line);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (def_line) uart_rx_def = bits[i];
      else          uart_rx     = bits[i];
      #(bns);
    end
  endtask

  task automatic send_frame(input logic [39:0] f, input int bns);
    for (int i = 0; i < 5; i++)
      send_byte(f[39-8*i -: 8], 1'b1, bns, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    uart_rx     = 1'b1;
    uart_rx_def = 1'b1;
    #35;
    check("reset_rx_data",  {24'd0, rx_data}, 32'h00);
    check("reset_cmd_id",   {24'd0, cmd_id}, 32'h00);
    check("reset_cmd_data", {16'd0, cmd_data}, 32'h0000);
    check("reset_strobes",  {28'd0, rx_valid, frame_err, cmd_valid, chk_err}, 32'h0);
    check("reset_def_rx_data", {24'd0, rx_data_def}, 32'h00);
    rst_n = 1'b1;
    #200;

    // Single byte at the default 115200 setting.
    send_byte(8'hA5, 1'b1, BIT_NS_DEF, 1'b1);
    #(2 * BIT_NS_DEF);
    settle();
    check("def_rxv_count",  n_rxv_def, 1);
    check("def_rx_data",    {24'd0, rx_data_def}, 32'hA5);
    check("def_frame_err",  n_ferr_def, 0);
    check("main_line_idle", n_rxv, 0);

    // Good frame, back-to-back bytes.
    snap();
    send_frame(40'h55_01_00_F0_F1, BIT_NS);
    #(3 * BIT_NS);
    settle();
    check("f1_rxv_count", n_rxv - b_rxv, 5);
    check("f1_cmd_count", n_cmd - b_cmd, 1);
    check("f1_cmd_id",    {24'd0, cmd_id}, 32'h01);
    check("f1_cmd_data",  {16'd0, cmd_data}, 32'h00F0);
    check("f1_cmd_lat",   cmd_lat, 1);
    check("f1_ferr",      n_ferr - b_ferr, 0);

    // Bad checksum: commands hold; then the corrected frame.
    snap();
    send_frame(40'h55_02_12_34_00, BIT_NS);
    #(3 * BIT_NS);
    settle();
    check("bad_chk_count", n_chk - b_chk, 1);
    check("bad_cmd_count", n_cmd - b_cmd, 0);
    check("bad_cmd_id",    {24'd0, cmd_id}, 32'h01);
    check("bad_cmd_data",  {16'd0, cmd_data}, 32'h00F0);
    send_frame(40'h55_02_12_34_48, BIT_NS);
    #(3 * BIT_NS);
    settle();
    check("fix_cmd_count", n_cmd - b_cmd, 1);
    check("fix_cmd_id",    {24'd0, cmd_id}, 32'h02);
    check("fix_cmd_data",  {16'd0, cmd_data}, 32'h1234);
    check("fix_chk_count", n_chk - b_chk, 1);

    // 0x55 inside the payload is data.
    snap();
    send_frame(40'h55_55_55_55_FF, BIT_NS);
    #(3 * BIT_NS);
    settle();
    check("f55_cmd_count", n_cmd - b_cmd, 1);
    check("f55_cmd_id",    {24'd0, cmd_id}, 32'h55);
    check("f55_cmd_data",  {16'd0, cmd_data}, 32'h5555);
    check("f55_rx_data",   {24'd0, rx_data}, 32'hFF);

    // Header, then a byte with a low stop bit, then a short idle glitch.
    // 01 02 03 06 would complete a frame if the parser had not been reset.
    snap();
    send_byte(8'h55, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h3C, 1'b0, BIT_NS, 1'b0);
    uart_rx = 1'b1;
    #(2 * BIT_NS);
    uart_rx = 1'b0;
    #300;
    uart_rx = 1'b1;
    #(2 * BIT_NS);
    settle();
    check("ferr_count",      n_ferr - b_ferr, 1);
    check("ferr_glitch_rxv", n_rxv - b_rxv, 1);
    check("ferr_rx_data",    {24'd0, rx_data}, 32'h55);
    send_byte(8'h01, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h02, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h03, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h06, 1'b1, BIT_NS, 1'b0);
    #(3 * BIT_NS);
    settle();
    check("ferr_hdr_cmd", n_cmd - b_cmd, 0);
    check("ferr_hdr_chk", n_chk - b_chk, 0);

    // Timeout: 55 03, 25 bit-times idle, then 10 20 33 (a valid tail otherwise).
    snap();
    send_byte(8'h55, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h03, 1'b1, BIT_NS, 1'b0);
    #(25 * BIT_NS);
    send_byte(8'h10, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h20, 1'b1, BIT_NS, 1'b0);
    send_byte(8'h33, 1'b1, BIT_NS, 1'b0);
    #(3 * BIT_NS);
    settle();
    check("tmo_rxv_count", n_rxv - b_rxv, 5);
    check("tmo_cmd_count", n_cmd - b_cmd, 0);
    check("tmo_chk_count", n_chk - b_chk, 0);

    // Baud tolerance: +2% and -2% bit periods.
    snap();
    send_frame(40'h55_07_00_09_10, 1020);
    #(3 * BIT_NS);
    settle();
    check("slow_cmd_count", n_cmd - b_cmd, 1);
    check("slow_cmd_id",    {24'd0, cmd_id}, 32'h07);
    check("slow_cmd_data",  {16'd0, cmd_data}, 32'h0009);
    snap();
    send_frame(40'h55_08_01_02_0B, 980);
    #(3 * BIT_NS);
    settle();
    check("fast_cmd_count", n_cmd - b_cmd, 1);
    check("fast_cmd_id",    {24'd0, cmd_id}, 32'h08);
    check("fast_cmd_data",  {16'd0, cmd_data}, 32'h0102);

    // Reset in the middle of a byte.
    fork
      send_byte(8'hC3, 1'b1, BIT_NS, 1'b0);
    join_none
    #(4 * BIT_NS);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data",  {24'd0, rx_data}, 32'h00);
    check("midrst_cmd_id",   {24'd0, cmd_id}, 32'h00);
    check("midrst_cmd_data", {16'd0, cmd_data}, 32'h0000);
    check("midrst_strobes",  {28'd0, rx_valid, frame_err, cmd_valid, chk_err}, 32'h0);
    #(7 * BIT_NS);
    rst_n = 1'b1;
    #(2 * BIT_NS);
    snap();
    send_byte(8'h5A, 1'b1, BIT_NS, 1'b0);
    #(2 * BIT_NS);
    settle();
    check("postrst_rxv",     n_rxv - b_rxv, 1);
    check("postrst_rx_data", {24'd0, rx_data}, 32'h5A);
    check("postrst_cmd_id",  {24'd0, cmd_id}, 32'h00);

    check("strobe_width", width_viol, 0);
    check("strobe_excl",  excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: sequence still running, expected to have finished");
    $fatal(1, "watchdog expired");
  end

endmodule
